// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed 8-digit common-anode hex display driver with frame-synchronous double buffering
module seg7_scan #(
    parameter int DIV   = 100000,
    parameter int GUARD = 16,
    parameter bit LZB   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] value,
    input  logic        load,
    input  logic [7:0]  digit_en,
    output logic [7:0]  AN,
    output logic [6:0]  Seg,
    output logic        frame_done
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [2:0]    r_idx, w_idx_n;
    logic [31:0]   r_pending, r_shadow, w_shadow_n;
    logic          w_tick, w_wrap, w_blank, w_guard;
    logic [3:0]    w_nib;
    logic [6:0]    w_hex;

    // next-state of the scan counters and shadow buffer; outputs are derived from these
    always_comb begin
        w_tick     = r_cnt == CW'(DIV - 1);
        w_wrap     = w_tick && r_idx == 3'd7;
        w_cnt_n    = w_tick ? '0 : r_cnt + 1'b1;
        w_idx_n    = w_tick ? r_idx + 3'd1 : r_idx;
        w_shadow_n = w_wrap ? (load ? value : r_pending) : r_shadow;
        w_nib      = w_shadow_n[{w_idx_n, 2'b00} +: 4];
        w_guard    = int'(w_cnt_n) < GUARD;
        w_blank    = !digit_en[w_idx_n] ||
                     (LZB && w_idx_n != 3'd0 && (w_shadow_n >> {w_idx_n, 2'b00}) == 32'd0);
    end

    // active-low segment pattern for the selected nibble
    always_comb begin
        w_hex = 7'h7F;
        case (w_nib)
            4'h0: w_hex = 7'h40;
            4'h1: w_hex = 7'h79;
            4'h2: w_hex = 7'h24;
            4'h3: w_hex = 7'h30;
            4'h4: w_hex = 7'h19;
            4'h5: w_hex = 7'h12;
            4'h6: w_hex = 7'h02;
            4'h7: w_hex = 7'h78;
            4'h8: w_hex = 7'h00;
            4'h9: w_hex = 7'h10;
            4'hA: w_hex = 7'h08;
            4'hB: w_hex = 7'h03;
            4'hC: w_hex = 7'h46;
            4'hD: w_hex = 7'h21;
            4'hE: w_hex = 7'h06;
            4'hF: w_hex = 7'h0E;
            default: w_hex = 7'h7F;
        endcase
    end

    // counters, buffers and registered display outputs; reset blanks the display at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_pending  <= '0;
            r_shadow   <= '0;
            AN         <= 8'hFF;
            Seg        <= 7'h7F;
            frame_done <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_n;
            r_idx      <= w_idx_n;
            r_shadow   <= w_shadow_n;
            if (load) r_pending <= value;
            Seg        <= w_blank ? 7'h7F : w_hex;
            AN         <= (w_blank || w_guard) ? 8'hFF : ~(8'd1 << w_idx_n);
            frame_done <= w_wrap;
        end
    end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: checks seg7_scan (LZB off and on) against a frame-level reference model
module tb_seg7_scan;
    localparam int DIV = 8, GUARD = 2, FR = 8 * DIV;
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  digit_en = 8'hFF;
    logic [7:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        fd0, fd1;

    always #5 clk = ~clk;

    seg7_scan #(.DIV(DIV), .GUARD(GUARD), .LZB(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .digit_en(digit_en),
        .AN(an0), .Seg(seg0), .frame_done(fd0));
    seg7_scan #(.DIV(DIV), .GUARD(GUARD), .LZB(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .digit_en(digit_en),
        .AN(an1), .Seg(seg1), .frame_done(fd1));

    int total = 0, bad = 0;
    int t = 0, fd_seen = 0;
    bit fresh = 1'b1;
    logic [31:0] m_pend = '0, m_shad = '0;

    typedef struct {
        logic [31:0] v;
        logic [7:0]  en;
        bit          lzb;
        int          d;
        logic [7:0]  an;
        logic [6:0]  seg;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
        end
    endtask

    // expected {AN, Seg} for the current cycle, from slot time, shadow value and live enables
    function automatic logic [14:0] model_out(input bit lzb);
        int i = (t / DIV) % 8;
        int c = t % DIV;
        logic [31:0] v = m_shad;
        bit blank;
        logic [7:0] an;
        for (int k = 0; k < i; k++) v = v / 16;
        blank = !digit_en[i] || (lzb && i > 0 && v == 0);
        an = (blank || c < GUARD) ? 8'hFF : 8'hFF - (8'd1 << i);
        return {an, blank ? 7'h7F : HEX[v % 16]};
    endfunction

    task automatic check_outs();
        logic [14:0] e0, e1;
        e0 = fresh ? {8'hFF, 7'h7F} : model_out(1'b0);
        e1 = fresh ? {8'hFF, 7'h7F} : model_out(1'b1);
        chk("an_lzb0", an0, e0[14:7]);
        chk("seg_lzb0", seg0, e0[6:0]);
        chk("an_lzb1", an1, e1[14:7]);
        chk("seg_lzb1", seg1, e1[6:0]);
        chk("frame_done0", fd0, !fresh && t % FR == 0);
        chk("frame_done1", fd1, !fresh && t % FR == 0);
    endtask

    task automatic step();
        @(posedge clk);
        if (t % FR == FR - 1) m_shad = load ? value : m_pend;
        if (load) m_pend = value;
        t++;
        fresh = 1'b0;
        #1;
        if (fd0) fd_seen++;
        check_outs();
    endtask

    task automatic load_val(input logic [31:0] v);
        load = 1'b1;
        value = v;
        step();
        load = 1'b0;
    endtask

    task automatic goto_pos(input int i, input int c);
        for (int n = 0; n < FR && t % FR != i * DIV + c; n++) step();
    endtask

    task automatic next_frame();
        step();
        goto_pos(0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_an0", an0, 8'hFF);
        chk("rst_seg0", seg0, 7'h7F);
        chk("rst_an1", an1, 8'hFF);
        chk("rst_seg1", seg1, 7'h7F);
        chk("rst_fd0", fd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        t = 0;
        fresh = 1'b1;
        m_pend = '0;
        m_shad = '0;
        check_outs();
    endtask

    task automatic add(input logic [31:0] v, input logic [7:0] en, input bit lzb,
                       input int d, input logic [7:0] an, input logic [6:0] seg);
        vec_t x;
        x.v = v; x.en = en; x.lzb = lzb; x.d = d; x.an = an; x.seg = seg;
        tv.push_back(x);
    endtask

    initial begin
        add(32'h89ABCDEF, 8'hFF, 0, 0, 8'hFE, 7'h0E);
        add(32'h89ABCDEF, 8'hFF, 0, 1, 8'hFD, 7'h06);
        add(32'h89ABCDEF, 8'hFF, 0, 2, 8'hFB, 7'h21);
        add(32'h89ABCDEF, 8'hFF, 0, 3, 8'hF7, 7'h46);
        add(32'h89ABCDEF, 8'hFF, 0, 4, 8'hEF, 7'h03);
        add(32'h89ABCDEF, 8'hFF, 0, 5, 8'hDF, 7'h08);
        add(32'h89ABCDEF, 8'hFF, 0, 6, 8'hBF, 7'h10);
        add(32'h89ABCDEF, 8'hFF, 0, 7, 8'h7F, 7'h00);
        add(32'h00000005, 8'hFF, 0, 0, 8'hFE, 7'h12);
        add(32'h00000005, 8'hFF, 0, 1, 8'hFD, 7'h40);
        add(32'h89ABCDEF, 8'h0F, 0, 4, 8'hFF, 7'h7F);
        add(32'h89ABCDEF, 8'h0F, 0, 7, 8'hFF, 7'h7F);
        add(32'h89ABCDEF, 8'h0F, 0, 2, 8'hFB, 7'h21);
        add(32'h00000A00, 8'hFF, 1, 0, 8'hFE, 7'h40);
        add(32'h00000A00, 8'hFF, 1, 1, 8'hFD, 7'h40);
        add(32'h00000A00, 8'hFF, 1, 2, 8'hFB, 7'h08);
        add(32'h00000A00, 8'hFF, 1, 3, 8'hFF, 7'h7F);
        add(32'h00000A00, 8'hFF, 1, 7, 8'hFF, 7'h7F);
        add(32'h00000A00, 8'hFF, 0, 3, 8'hF7, 7'h40);
        add(32'h00000000, 8'hFF, 1, 0, 8'hFE, 7'h40);
        add(32'h00000000, 8'hFF, 1, 1, 8'hFF, 7'h7F);

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        step();
        chk("guard_an", an0, 8'hFF);
        step();
        chk("d0_an", an0, 8'hFE);
        chk("d0_seg", seg0, 7'h40);
        fd_seen = 0;
        repeat (2 * FR) step();
        chk("fd_per_frame", fd_seen, 2);

        goto_pos(2, 3);
        load_val(32'h89ABCDEF);
        goto_pos(4, 4);
        chk("no_tear_seg", seg0, 7'h40);
        fd_seen = 0;
        goto_pos(0, 0);
        chk("wrap_fd", fd0, 1'b1);
        goto_pos(0, 4);
        chk("new_frame_seg", seg0, 7'h0E);
        goto_pos(7, 7);
        chk("fd_once", fd_seen, 1);

        next_frame();
        goto_pos(1, 0);
        load_val(32'h11111111);
        goto_pos(3, 0);
        load_val(32'h22222222);
        next_frame();
        goto_pos(5, 4);
        chk("last_load_wins", seg0, 7'h24);

        goto_pos(7, 7);
        load_val(32'h00000005);
        goto_pos(0, 2);
        chk("bypass_an", an0, 8'hFE);
        chk("bypass_seg", seg0, 7'h12);
        goto_pos(1, 3);
        chk("bypass_d1", seg0, 7'h40);

        foreach (tv[k]) begin
            digit_en = tv[k].en;
            load_val(tv[k].v);
            next_frame();
            goto_pos(tv[k].d, 4);
            chk($sformatf("vec%0d_an", k), tv[k].lzb ? an1 : an0, tv[k].an);
            chk($sformatf("vec%0d_seg", k), tv[k].lzb ? seg1 : seg0, tv[k].seg);
        end
        digit_en = 8'hFF;

        repeat (600) begin
            digit_en = ($urandom % 4 == 0) ? 8'($urandom) : 8'hFF;
            load = ($urandom % 12 == 0);
            value = $urandom >> ($urandom % 32);
            step();
            load = 1'b0;
        end
        digit_en = 8'hFF;

        load_val(32'h76543210);
        next_frame();
        goto_pos(5, 3);
        do_reset();
        goto_pos(0, 2);
        chk("post_rst_an", an0, 8'hFE);
        chk("post_rst_seg", seg0, 7'h40);
        goto_pos(6, 4);
        chk("post_rst_d6", seg0, 7'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Downstream display stage for the CPU: drives the board's 8-digit common-anode seven-segment display (AN/Seg pins) from a 32-bit value produced by the CPU.
- Time-multiplexes 8 hex digits with a programmable refresh rate and inter-digit guard blanking.
- Double-buffers the value so that updates take effect only at frame boundaries, which prevents tearing.
- Supports per-digit enable and optional leading-zero blanking.

Parameters:
- DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz). Legal range is DIV >= 4.
- GUARD, 16: cycles at the start of each slot during which all anodes are off (anti-ghosting). Legal range is 0 <= GUARD < DIV.
- LZB, 0: 1 enables leading-zero blanking.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- value  in  32  display data; nibble i is shown on digit i (digit 0 = rightmost)
- load  in  1  single-cycle strobe; captures value into the pending buffer
- digit_en  in  8  per-digit enable; 0 forces that digit dark
- AN  out  8  anode selects, active low
- Seg  out  7  segments {g,f,e,d,c,b,a}, active low
- frame_done  out  1  one-cycle pulse when the shadow buffer is updated (frame wrap)

Behaviour:
- Reset (async assert on rst_n low, sync release), all values below:
  - AN = 8'hFF, Seg = 7'h7F, frame_done = 0
  - slot counter cnt = 0, digit index idx = 0
  - pending = 0, shadow = 0
- Counters:
  - cnt counts 0..DIV-1, then wraps to 0.
  - tick is asserted when cnt == DIV-1.
  - On tick, idx <= idx+1 mod 8.
- Frame boundary = tick with idx == 7.
  - At that edge: shadow <= (load ? value : pending); frame_done = 1 for exactly that cycle (registered, asserted the cycle after the boundary edge... see next line).
  - Precisely: frame_done is high during the cycle in which idx == 0 and cnt == 0, following a wrap.
- Load:
  - When load is high, pending <= value.
  - Back-to-back loads: the last one before the boundary wins.
  - load coincident with the boundary edge bypasses pending into shadow and also writes pending.
- Outputs are registered and computed from the next-state (idx, cnt, shadow), so they agree with the counters in the same cycle.
  - Seg = hex pattern of shadow[4*idx+3 : 4*idx], or 7'h7F when the digit is blanked.
  - AN = 8'hFF when cnt < GUARD or the digit is blanked; otherwise AN = ~(1 << idx).
- A digit is blanked when either condition holds:
  - digit_en[idx] == 0
  - LZB == 1, idx > 0, and every nibble from idx to 7 of shadow is zero
  - Digit 0 is never LZB-blanked.
- Hex table, active low (0..F): 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E.
- digit_en is sampled live every cycle and is not buffered.
- Reset mid-frame:
  - Outputs go dark immediately.
  - Scan restarts at digit 0, cnt 0, with shadow = 0 (displays "0" on enabled digits after GUARD).
- No combinational path from any input to any output.

Test Plan:
- Bench settings: DIV=8, GUARD=2, LZB=0.
- Reset release with value untouched, digit_en=FF:
  - AN=FF for cnt 0..1.
  - Then AN=FE, Seg=40 for cnt 2..7.
  - Then AN=FF for 2 cycles, then AN=FD, Seg=40.
  - Full frame = 64 cycles; frame_done pulses every 64 cycles.
- load=1 with value=32'h89ABCDEF at cnt=3, idx=2:
  - Display is unchanged until the wrap.
  - Next frame shows digit0=0E, d1=06, d2=21, d3=46, d4=03, d5=08, d6=10, d7=00.
  - frame_done pulses once at the frame start.
- Two loads in one frame (11111111 then 22222222):
  - Next frame shows all digits Seg=24.
- load at the exact boundary cycle (idx=7, cnt=7) with 32'h0000_0005:
  - The following frame shows it immediately (d0=12, others 40).
- digit_en=8'h0F:
  - AN stays FF and Seg=7F during slots 4..7.
  - Slots 0..3 scan normally.
- LZB=1 with value=32'h0000_0A00:
  - Digits 3..7 are dark.
  - Digits 0..2 show 40, 40, 08.
- LZB=1 with value=0:
  - Only digit 0 lit (Seg=40).
- rst_n pulled low mid-slot (idx=5):
  - AN=FF and Seg=7F in the same cycle, with no clock needed.
  - After release, the scan restarts at digit 0 and shadow reads 0.
